cvp14_fetch_unit: RTL and testbench

//  Instruction fetch stage for the CVP14 core. Sits between the DRAM read port and decode.

---
 rtl/cvp14_fetch_unit_if.sv | 26 ++
 rtl/cvp14_fetch_unit.sv | 95 +++++++++
 tb/tb_cvp14_fetch_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cvp14_fetch_unit_if.sv
// rtl/cvp14_fetch_unit_if.sv - DRAM read port and decode handshake bundle for the fetch unit
interface cvp14_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] Addr;
    logic              RD;
    logic [DATA_W-1:0] DataIn;
    logic              Grant;
    logic              Redirect;
    logic [ADDR_W-1:0] RedirectPC;
    logic [DATA_W-1:0] Instruction;
    logic [ADDR_W-1:0] InstPC;
    logic              InstValid;
    logic              InstReady;

    modport master (
        output Addr, RD, Instruction, InstPC, InstValid,
        input  DataIn, Grant, Redirect, RedirectPC, InstReady
    );

    modport slave (
        input  Addr, RD, Instruction, InstPC, InstValid,
        output DataIn, Grant, Redirect, RedirectPC, InstReady
    );
endinterface

// File: rtl/cvp14_fetch_unit.sv
// rtl/cvp14_fetch_unit.sv - CVP14 instruction fetch: sequential DRAM reads, in-flight tracking, instruction FIFO
module cvp14_fetch_unit #(
    parameter int          ADDR_W     = 16,
    parameter int          DATA_W     = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MEM_LAT    = 1,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  Clk1,
    input  logic                  Reset,
    cvp14_fetch_unit_if.master    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + MEM_LAT + 1) + 1;

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [MEM_LAT-1:0] fl_vld_q, fl_vld_d;
    logic [ADDR_W-1:0]  fl_pc_q [MEM_LAT];
    logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fifo_pc_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    logic [OCC_W-1:0]   inflight;
    logic [OCC_W-1:0]   occupancy;
    logic               issue;
    logic               push;
    logic               pop;

    // Reads already issued reserve a FIFO slot, so the buffer can never overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + OCC_W'(fl_vld_q[i]);
        end
        occupancy = OCC_W'(count_q) + inflight;
        issue     = bus.Grant && !bus.Redirect && !Reset && (occupancy < OCC_W'(FIFO_DEPTH));
        push      = fl_vld_q[MEM_LAT-1] && !bus.Redirect && !Reset;
        pop       = (count_q != '0) && bus.InstReady && !bus.Redirect && !Reset;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(issue);
        count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        fl_vld_d   = '0;
        fl_vld_d[0] = issue;
        for (int i = 1; i < MEM_LAT; i++) begin
            fl_vld_d[i] = fl_vld_q[i-1];
        end
        if (bus.Redirect) begin
            fetch_pc_d = bus.RedirectPC;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fl_vld_d   = '0;
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            fetch_pc_q <= ADDR_W'(RESET_PC);
            fl_vld_q   <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fl_vld_q   <= fl_vld_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in fl_vld_q and count_q.
    always_ff @(posedge Clk1) begin
        fl_pc_q[0] <= fetch_pc_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            fl_pc_q[i] <= fl_pc_q[i-1];
        end
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.DataIn;
            fifo_pc_q[wr_ptr_q]   <= fl_pc_q[MEM_LAT-1];
        end
    end

    assign bus.RD          = issue;
    assign bus.Addr        = fetch_pc_q;
    assign bus.InstValid   = (count_q != '0);
    assign bus.Instruction = bus.InstValid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.InstPC      = bus.InstValid ? fifo_pc_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_cvp14_fetch_unit.sv
// tb/tb_cvp14_fetch_unit.sv - randomized self-checking bench for cvp14_fetch_unit
module tb_cvp14_fetch_unit;
    localparam int DEPTH   = 4;
    localparam int MEM_LAT = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cvp14_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    cvp14_fetch_unit #(
        .ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .RESET_PC(0)
    ) dut (
        .Clk1  (clk),
        .Reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dram(input logic [15:0] a);
        return (a + 16'd1) * 16'h1111;
    endfunction

    typedef struct {
        int unsigned ready_at;
        logic [15:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [15:0] issue_pc = 16'h0000;
    int unsigned ecnt = 0;
    logic [15:0] acc_log[$];
    int          rd_pulses;

    logic        pipe_v [MEM_LAT];
    logic [15:0] pipe_a [MEM_LAT];

    logic        s_valid, s_rd;
    logic [15:0] s_addr, s_inst, s_pc;

    // One clock: drive inputs, check against the model, let the edge happen, advance model and DRAM.
    task automatic cyc(input bit g, input bit r, input logic [15:0] rp, input bit rdy,
                       input bit rst, input bit chk_en);
        bit          exp_rd, exp_v, acc, m_rd;
        logic [15:0] m_addr;
        int unsigned e;
        @(negedge clk);
        bus.Grant = g; bus.Redirect = r; bus.RedirectPC = rp; bus.InstReady = rdy; reset = rst;
        #1;
        e      = ecnt;
        exp_rd = g && !r && !rst && (q.size() < DEPTH);
        exp_v  = (q.size() > 0) && (q[0].ready_at <= e);
        s_valid = bus.InstValid; s_rd = bus.RD; s_addr = bus.Addr;
        s_inst  = bus.Instruction; s_pc = bus.InstPC;
        if (chk_en) begin
            check_eq("rd", 32'(bus.RD), 32'(exp_rd));
            if (exp_rd) check_eq("addr", 32'(bus.Addr), 32'(issue_pc));
            check_eq("valid", 32'(bus.InstValid), 32'(exp_v));
            if (exp_v) begin
                check_eq("instpc", 32'(bus.InstPC), 32'(q[0].pc));
                check_eq("inst", 32'(bus.Instruction), 32'(dram(q[0].pc)));
            end
        end
        acc    = exp_v && rdy && !r && !rst;
        m_rd   = bus.RD;
        m_addr = bus.Addr;
        if (m_rd) rd_pulses++;
        if (acc) acc_log.push_back(q[0].pc);
        @(posedge clk);
        ecnt++;
        if (rst) begin
            q.delete();
            issue_pc = 16'h0000;
        end else if (r) begin
            q.delete();
            issue_pc = rp;
        end else begin
            if (acc) void'(q.pop_front());
            if (exp_rd) begin
                q.push_back('{ready_at: e + MEM_LAT + 1, pc: issue_pc});
                issue_pc = issue_pc + 16'd1;
            end
        end
        #1;
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_a[i] = pipe_a[i-1];
        end
        pipe_v[0] = m_rd;
        pipe_a[0] = m_addr;
        bus.DataIn = pipe_v[MEM_LAT-1] ? dram(pipe_a[MEM_LAT-1]) : 16'($urandom);
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < acc_log.size()) ? 32'(acc_log[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic do_reset();
        cyc(1, 0, 16'h0, 1, 1, 1);
        acc_log.delete();
        rd_pulses = 0;
    endtask

    initial begin
        int first_v;
        int first_addr;
        int g0_rd;
        bit g, rdy, r, rst;
        logic [15:0] rp;
        for (int i = 0; i < MEM_LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = '0;
        end
        bus.DataIn = '0; bus.Grant = 0; bus.Redirect = 0; bus.RedirectPC = '0; bus.InstReady = 0;
        reset = 1;
        rd_pulses = 0;

        cyc(0, 0, 16'h0, 0, 1, 0);
        cyc(1, 0, 16'h0, 1, 1, 1);
        check_eq("rst_valid", 32'(s_valid), 32'd0);
        check_eq("rst_rd", 32'(s_rd), 32'd0);
        check_eq("rst_addr", 32'(s_addr), 32'd0);
        check_eq("rst_inst", 32'(s_inst), 32'd0);
        check_eq("rst_pc", 32'(s_pc), 32'd0);

        // T1 latency and in-order stream from 0
        do_reset();
        first_v = -1;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 16'h0, 1, 0, 1);
            if (s_valid && first_v < 0) first_v = i;
        end
        check_eq("t1_latency", 32'(first_v), 32'(MEM_LAT + 1));
        for (int i = 0; i < 6; i++) check_eq("t1_seq", log_at(i), 32'(i));

        // T2 decode stall fills buffer, then drains in order
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 0, 16'h0, 0, 0, 1);
        check_eq("t2_rd_pulses", 32'(rd_pulses), 32'(DEPTH));
        first_addr = -1;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 16'h0, 1, 0, 1);
            if (s_rd && first_addr < 0) first_addr = int'(s_addr);
        end
        for (int i = 0; i < 4; i++) check_eq("t2_drain", log_at(i), 32'(i));
        check_eq("t2_resume_addr", 32'(first_addr), 32'd4);

        // T3 Grant pattern 1,0,0,1
        do_reset();
        g0_rd = 0;
        for (int i = 0; i < 16; i++) begin
            g = (i % 4 == 0) || (i % 4 == 3);
            cyc(g, 0, 16'h0, 1, 0, 1);
            if (!g && s_rd) g0_rd++;
        end
        check_eq("t3_rd_no_grant", 32'(g0_rd), 32'd0);
        for (int i = 0; i < 4; i++) check_eq("t3_seq", log_at(i), 32'(i));

        // T4 redirect with data buffered and in flight
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0, 0, 0, 1);
        cyc(1, 1, 16'h0040, 1, 0, 1);
        check_eq("t4_rd_in_redirect", 32'(s_rd), 32'd0);
        acc_log.delete();
        cyc(1, 0, 16'h0, 1, 0, 1);
        check_eq("t4_valid_after", 32'(s_valid), 32'd0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 16'h0, 1, 0, 1);
        check_eq("t4_first", log_at(0), 32'h0040);
        check_eq("t4_second", log_at(1), 32'h0041);

        // T5 address wrap
        cyc(1, 1, 16'hFFFE, 1, 0, 1);
        acc_log.delete();
        for (int i = 0; i < 8; i++) cyc(1, 0, 16'h0, 1, 0, 1);
        check_eq("t5_wrap0", log_at(0), 32'hFFFE);
        check_eq("t5_wrap1", log_at(1), 32'hFFFF);
        check_eq("t5_wrap2", log_at(2), 32'h0000);
        check_eq("t5_wrap3", log_at(3), 32'h0001);

        // T6 reset while full
        for (int i = 0; i < 8; i++) cyc(1, 0, 16'h0, 0, 0, 1);
        cyc(1, 0, 16'h0, 1, 1, 1);
        cyc(1, 0, 16'h0, 1, 1, 1);
        check_eq("t6_valid", 32'(s_valid), 32'd0);
        check_eq("t6_rd", 32'(s_rd), 32'd0);
        check_eq("t6_addr", 32'(s_addr), 32'd0);
        acc_log.delete();
        for (int i = 0; i < 6; i++) cyc(1, 0, 16'h0, 1, 0, 1);
        check_eq("t6_refetch", log_at(0), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            g   = ($urandom % 4) != 0;
            rdy = ($urandom % 3) != 0;
            r   = ($urandom % 40) == 0;
            rst = ($urandom % 200) == 0;
            rp  = (($urandom % 3) == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
            cyc(g, r, rp, rdy, rst, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
